// File: rtl/spi_inst_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_inst_rx
//  Description : SPI-style serial word receiver. While spi_ss is low, one
//                spi_mosi bit is sampled per clk_i cycle, MSB first. Each word
//                of DATA_WIDTH bits is followed by one discarded gap cycle.
//                Assembled words are queued in a small FIFO with a
//                valid/ready output. A 16-bit push counter is provided, and two
//                sticky error flags report overflow and aborted frames.
//                Optional macro SPI_INST_RX_SYNC_EN: when defined, spi_ss and
//                spi_mosi pass through two-flop synchronizers before the FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_inst_rx #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  spi_ss,
    input  logic                  spi_mosi,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_valid_o,
    input  logic                  word_ready_i,
    output logic [15:0]           word_count_o,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic                  frame_err_o
);

    // Bit counter must hold values up to DATA_WIDTH.
    localparam int c_cnt_w = $clog2(DATA_WIDTH + 1);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    logic                  w_ss;
    logic                  w_mosi;
    state_t                r_state;
    logic [c_cnt_w-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-2:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_push;
    logic                  r_frame_err;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w:0]      r_wr_ptr;
    logic [c_ptr_w:0]      r_rd_ptr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push_ok;
    logic                  r_overflow;
    logic [15:0]           r_word_count;

`ifdef SPI_INST_RX_SYNC_EN
    logic [1:0] r_ss_sync;
    logic [1:0] r_mosi_sync;

    // Two-flop synchronizers; ss idles high so reset never looks like a frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ss_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
        end else begin
            r_ss_sync   <= {r_ss_sync[0], spi_ss};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
        end
    end

    assign w_ss   = r_ss_sync[1];
    assign w_mosi = r_mosi_sync[1];
`else
    assign w_ss   = spi_ss;
    assign w_mosi = spi_mosi;
`endif

    // The incoming bit completes the word; the oldest bit lands in the MSB.
    assign w_shift_next = {r_shift, w_mosi};
    assign w_push       = (r_state == S_SHIFT) && !w_ss && (r_bit_cnt == c_last_bit);

    // Receive FSM: frame tracking, bit assembly and abort detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_ss) begin
                        r_shift   <= w_shift_next[DATA_WIDTH-2:0];
                        r_bit_cnt <= c_cnt_w'(1);
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_ss) begin
                        // A count of zero means the frame ended cleanly after a gap.
                        if (r_bit_cnt != '0) begin
                            r_frame_err <= 1'b1;
                        end
                        r_bit_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_shift   <= w_shift_next[DATA_WIDTH-2:0];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    r_bit_cnt <= '0;
                    r_state   <= w_ss ? S_IDLE : S_SHIFT;
                end
                default: begin
                    r_bit_cnt <= '0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Pointers carry one extra wrap bit to tell full from empty.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                       (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_pop     = !w_empty && word_ready_i;
    assign w_push_ok = w_push && (!w_full || w_pop);

    // Output FIFO, push counter and overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[c_ptr_w-1:0]] <= w_shift_next;
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_word_count <= r_word_count + 16'd1;
            end else if (w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign word_o       = r_mem[r_rd_ptr[c_ptr_w-1:0]];
    assign word_valid_o = !w_empty;
    assign word_count_o = r_word_count;
    assign busy_o       = (r_state != S_IDLE);
    assign overflow_o   = r_overflow;
    assign frame_err_o  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_inst_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_inst_rx
//  Description : Directed self-checking bench for spi_inst_rx. Inputs change
//                on the falling clock edge; a monitor logs every popped word
//                and its cycle number. Honours SPI_INST_RX_SYNC_EN (+2 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_inst_rx;

`ifdef SPI_INST_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    localparam logic [31:0] WV [5] = '{32'h11111111, 32'h22222222, 32'h33333333,
                                       32'h44444444, 32'h55555555};

    logic        clk_i        = 1'b0;
    logic        rst_ni       = 1'b1;
    logic        spi_ss       = 1'b1;
    logic        spi_mosi     = 1'b0;
    logic        word_ready_i = 1'b0;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic [15:0] word_count_o;
    logic        busy_o;
    logic        overflow_o;
    logic        frame_err_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [31:0] q_word [$];
    int          q_cyc  [$];

    spi_inst_rx #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .spi_ss       (spi_ss),
        .spi_mosi     (spi_mosi),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .word_count_o (word_count_o),
        .busy_o       (busy_o),
        .overflow_o   (overflow_o),
        .frame_err_o  (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Log each handshake mid-low-phase, i.e. the word taken at the next rising edge.
    always @(negedge clk_i) begin
        #3;
        if (word_valid_o === 1'b1 && word_ready_i === 1'b1) begin
            q_word.push_back(word_o);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        if (i < q_word.size()) return q_word[i];
        return 32'hBAD0BAD0;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < q_cyc.size()) return q_cyc[i];
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        #2;
        rst_ni       = 1'b0;
        spi_ss       = 1'b1;
        spi_mosi     = 1'b0;
        word_ready_i = 1'b0;
        q_word.delete();
        q_cyc.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits, output int last_cyc);
        last_cyc = cyc;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_i);
            spi_ss   = 1'b0;
            spi_mosi = w[31-i];
            last_cyc = cyc;
        end
    endtask

    // Full word plus its gap bit; optionally raise ready exactly when the push lands.
    task automatic send_word(input logic [31:0] w, input bit ready_on_last, output int last_cyc);
        send_bits(w, 32, last_cyc);
        if (ready_on_last) begin
            fork
                begin
                    repeat (LAT) @(negedge clk_i);
                    word_ready_i = 1'b1;
                end
            join_none
        end
        @(negedge clk_i);
        spi_ss   = 1'b0;
        spi_mosi = ~w[0];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            spi_ss   = 1'b1;
            spi_mosi = 1'b0;
        end
    endtask

    initial begin
        int l0;
        int l1;
        int l2;

        // Asynchronous reset with no clock edge in between
        #2 rst_ni = 1'b0;
        #1;
        check_eq("rst word_o",  word_o, 32'h0);
        check_eq("rst valid",   32'(word_valid_o), 32'h0);
        check_eq("rst count",   32'(word_count_o), 32'h0);
        check_eq("rst busy",    32'(busy_o), 32'h0);
        check_eq("rst ovf",     32'(overflow_o), 32'h0);
        check_eq("rst ferr",    32'(frame_err_o), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        idle(2);

        // Single word, latency of one cycle after the last bit
        word_ready_i = 1'b1;
        send_word(32'h00000013, 1'b0, l0);
        idle(4 + LAT);
        check_eq("single nwords", q_word.size(), 32'd1);
        check_eq("single word",   word_at(0), 32'h00000013);
        check_eq("single lat",    cyc_at(0), l0 + 1 + LAT);
        check_eq("single count",  32'(word_count_o), 32'd1);
        check_eq("single ferr",   32'(frame_err_o), 32'h0);

        // Back-to-back words, 33 cycles apart
        do_reset();
        word_ready_i = 1'b1;
        send_word(32'hDEADBEEF, 1'b0, l0);
        send_word(32'h12345678, 1'b0, l1);
        send_word(32'h0000005A, 1'b0, l2);
        idle(4 + LAT);
        check_eq("b2b nwords", q_word.size(), 32'd3);
        check_eq("b2b w0",     word_at(0), 32'hDEADBEEF);
        check_eq("b2b w1",     word_at(1), 32'h12345678);
        check_eq("b2b w2",     word_at(2), 32'h0000005A);
        check_eq("b2b lat0",   cyc_at(0), l0 + 1 + LAT);
        check_eq("b2b gap01",  cyc_at(1) - cyc_at(0), 32'd33);
        check_eq("b2b gap12",  cyc_at(2) - cyc_at(1), 32'd33);
        check_eq("b2b count",  32'(word_count_o), 32'd3);
        check_eq("b2b ovf",    32'(overflow_o), 32'h0);
        check_eq("b2b ferr",   32'(frame_err_o), 32'h0);

        // Overflow: five words into a four-deep FIFO with no consumer
        do_reset();
        for (int k = 0; k < 5; k++) send_word(WV[k], 1'b0, l0);
        idle(3 + LAT);
        check_eq("ovf count",  32'(word_count_o), 32'd4);
        check_eq("ovf flag",   32'(overflow_o), 32'h1);
        check_eq("ovf valid",  32'(word_valid_o), 32'h1);
        check_eq("ovf head",   word_o, WV[0]);
        @(negedge clk_i);
        word_ready_i = 1'b1;
        idle(8);
        check_eq("ovf nwords", q_word.size(), 32'd4);
        for (int k = 0; k < 4; k++) check_eq($sformatf("ovf w%0d", k), word_at(k), WV[k]);
        check_eq("ovf pop rate", cyc_at(1) - cyc_at(0), 32'd1);
        check_eq("ovf drained",  32'(word_valid_o), 32'h0);
        check_eq("ovf sticky",   32'(overflow_o), 32'h1);

        // Abort after 10 bits, then a clean word
        do_reset();
        word_ready_i = 1'b1;
        send_bits(32'hFFFF0000, 10, l0);
        @(negedge clk_i);
        spi_ss = 1'b1;
        repeat (1 + LAT) @(posedge clk_i);
        #1;
        check_eq("abort busy",  32'(busy_o), 32'h0);
        check_eq("abort ferr",  32'(frame_err_o), 32'h1);
        check_eq("abort count", 32'(word_count_o), 32'h0);
        idle(2);
        send_word(32'hCAFEF00D, 1'b0, l0);
        idle(4 + LAT);
        check_eq("abort nwords", q_word.size(), 32'd1);
        check_eq("abort word",   word_at(0), 32'hCAFEF00D);
        check_eq("abort count2", 32'(word_count_o), 32'd1);
        check_eq("abort sticky", 32'(frame_err_o), 32'h1);

        // Reset pulse 20 bits into the second word
        do_reset();
        send_word(32'h0F0F0F0F, 1'b0, l0);
        send_bits(32'hFFFFFFFF, 20, l0);
        #2;
        check_eq("midrst pre busy",  32'(busy_o), 32'h1);
        check_eq("midrst pre valid", 32'(word_valid_o), 32'h1);
        rst_ni = 1'b0;
        spi_ss = 1'b1;
        #1;
        check_eq("midrst word_o", word_o, 32'h0);
        check_eq("midrst valid",  32'(word_valid_o), 32'h0);
        check_eq("midrst count",  32'(word_count_o), 32'h0);
        check_eq("midrst busy",   32'(busy_o), 32'h0);
        check_eq("midrst ferr",   32'(frame_err_o), 32'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        idle(3);
        word_ready_i = 1'b1;
        send_word(32'hA5A5A5A5, 1'b0, l0);
        idle(4 + LAT);
        check_eq("midrst nwords", q_word.size(), 32'd1);
        check_eq("midrst word",   word_at(0), 32'hA5A5A5A5);
        check_eq("midrst count2", 32'(word_count_o), 32'd1);
        check_eq("midrst ferr2",  32'(frame_err_o), 32'h0);

        // Full FIFO: pop lands on the same edge as the fifth push
        do_reset();
        for (int k = 0; k < 4; k++) send_word(WV[k], 1'b0, l0);
        send_word(WV[4], 1'b1, l0);
        idle(8 + LAT);
        check_eq("fullpp count",  32'(word_count_o), 32'd5);
        check_eq("fullpp ovf",    32'(overflow_o), 32'h0);
        check_eq("fullpp nwords", q_word.size(), 32'd5);
        for (int k = 0; k < 5; k++) check_eq($sformatf("fullpp w%0d", k), word_at(k), WV[k]);
        check_eq("fullpp same edge", cyc_at(0), l0 + LAT);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
